// File: rtl/mmu_tlb_if.sv
// mmu_tlb_if: request/response bundle between the pipeline/CP0 side (master)
// and the joint TLB / address-translation unit (slave).
interface mmu_tlb_if;
    logic        stallM;
    logic        inst_en;
    logic [31:0] inst_vaddr;
    logic        data_en;
    logic        mem_write;
    logic [31:0] data_vaddr;
    logic [3:0]  tlb_type;
    logic [31:0] entry_hi_W;
    logic [31:0] page_mask_W;
    logic [31:0] entry_lo0_W;
    logic [31:0] entry_lo1_W;
    logic [31:0] index_W;
    logic [31:0] random_i;

    logic [31:0] inst_paddr;
    logic [31:0] data_paddr;
    logic        inst_uncached;
    logic        data_uncached;
    logic        inst_tlb_refill;
    logic        inst_tlb_invalid;
    logic        data_tlb_refill;
    logic        data_tlb_invalid;
    logic        data_tlb_modify;
    logic [31:0] index_out;
    logic [31:0] entry_hi_out;
    logic [31:0] page_mask_out;
    logic [31:0] entry_lo0_out;
    logic [31:0] entry_lo1_out;
    logic        itlb_stall;

    modport master (
        output stallM, inst_en, inst_vaddr, data_en, mem_write, data_vaddr, tlb_type,
               entry_hi_W, page_mask_W, entry_lo0_W, entry_lo1_W, index_W, random_i,
        input  inst_paddr, data_paddr, inst_uncached, data_uncached,
               inst_tlb_refill, inst_tlb_invalid, data_tlb_refill, data_tlb_invalid,
               data_tlb_modify, index_out, entry_hi_out, page_mask_out,
               entry_lo0_out, entry_lo1_out, itlb_stall
    );

    modport slave (
        input  stallM, inst_en, inst_vaddr, data_en, mem_write, data_vaddr, tlb_type,
               entry_hi_W, page_mask_W, entry_lo0_W, entry_lo1_W, index_W, random_i,
        output inst_paddr, data_paddr, inst_uncached, data_uncached,
               inst_tlb_refill, inst_tlb_invalid, data_tlb_refill, data_tlb_invalid,
               data_tlb_modify, index_out, entry_hi_out, page_mask_out,
               entry_lo0_out, entry_lo1_out, itlb_stall
    );
endinterface

// File: rtl/mmu_tlb.sv
// mmu_tlb: joint TLB and address-translation unit.
// Combinational fetch/data translation and TLBP probe, TLBR readback at Index,
// TLBWI/TLBWR writes on the clock edge while the memory stage is not stalled.
// Optional macro MMU_ITLB_CACHE_EN adds a one-entry instruction micro-TLB that
// raises itlb_stall for one cycle on a mapped fetch miss.
module mmu_tlb #(
    parameter int TLB_LINE_NUM = 16,
    parameter int INDEX_W      = 4
) (
    input logic      clk,
    input logic      rst,
    mmu_tlb_if.slave bus
);
    logic [18:0] r_vpn2 [TLB_LINE_NUM];
    logic [7:0]  r_asid [TLB_LINE_NUM];
    logic        r_g    [TLB_LINE_NUM];
    logic [11:0] r_mask [TLB_LINE_NUM];
    logic [19:0] r_pfn0 [TLB_LINE_NUM];
    logic [19:0] r_pfn1 [TLB_LINE_NUM];
    logic [2:0]  r_c0   [TLB_LINE_NUM];
    logic [2:0]  r_c1   [TLB_LINE_NUM];
    logic        r_d0   [TLB_LINE_NUM];
    logic        r_d1   [TLB_LINE_NUM];
    logic        r_v0   [TLB_LINE_NUM];
    logic        r_v1   [TLB_LINE_NUM];

    // Lowest matching index wins; 0 when nothing matches.
    function automatic logic [INDEX_W-1:0] first_hit(input logic [TLB_LINE_NUM-1:0] m);
        logic [INDEX_W-1:0] idx;
        idx = '0;
        for (int i = TLB_LINE_NUM - 1; i >= 0; i--) begin
            if (m[i]) idx = INDEX_W'(i);
        end
        return idx;
    endfunction

    logic               w_wr_en;
    logic [INDEX_W-1:0] w_wr_idx;
    assign w_wr_en  = !bus.stallM && (bus.tlb_type[3] || bus.tlb_type[2]);
    assign w_wr_idx = bus.tlb_type[2] ? bus.index_W[INDEX_W-1:0] : bus.random_i[INDEX_W-1:0];

    // Entry array: cleared by reset, one entry replaced per TLBWI/TLBWR.
    // NOTE: the table is reset in full because every lookup reads all entries
    // combinationally; reset also takes priority over a write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TLB_LINE_NUM; i++) begin
                r_vpn2[i] <= '0;  r_asid[i] <= '0;  r_g[i]  <= 1'b0; r_mask[i] <= '0;
                r_pfn0[i] <= '0;  r_pfn1[i] <= '0;  r_c0[i] <= '0;   r_c1[i]   <= '0;
                r_d0[i]   <= 1'b0; r_d1[i]  <= 1'b0; r_v0[i] <= 1'b0; r_v1[i]   <= 1'b0;
            end
        end else if (w_wr_en) begin
            // NOTE: non-blocking, so lookups in the write cycle still see the old entry.
            r_vpn2[w_wr_idx] <= bus.entry_hi_W[31:13];
            r_asid[w_wr_idx] <= bus.entry_hi_W[7:0];
            r_g[w_wr_idx]    <= bus.entry_lo0_W[0] & bus.entry_lo1_W[0];
            r_mask[w_wr_idx] <= bus.page_mask_W[24:13];
            r_pfn0[w_wr_idx] <= bus.entry_lo0_W[25:6];
            r_c0[w_wr_idx]   <= bus.entry_lo0_W[5:3];
            r_d0[w_wr_idx]   <= bus.entry_lo0_W[2];
            r_v0[w_wr_idx]   <= bus.entry_lo0_W[1];
            r_pfn1[w_wr_idx] <= bus.entry_lo1_W[25:6];
            r_c1[w_wr_idx]   <= bus.entry_lo1_W[5:3];
            r_d1[w_wr_idx]   <= bus.entry_lo1_W[2];
            r_v1[w_wr_idx]   <= bus.entry_lo1_W[1];
        end
    end

    logic [TLB_LINE_NUM-1:0] w_i_match, w_d_match, w_p_match;

    // Tag compare of every entry against the fetch, data and probe addresses.
    always_comb begin
        for (int i = 0; i < TLB_LINE_NUM; i++) begin
            w_i_match[i] = (r_vpn2[i] == bus.inst_vaddr[31:13]) &&
                           (r_g[i] || (r_asid[i] == bus.entry_hi_W[7:0]));
            w_d_match[i] = (r_vpn2[i] == bus.data_vaddr[31:13]) &&
                           (r_g[i] || (r_asid[i] == bus.entry_hi_W[7:0]));
            w_p_match[i] = (r_vpn2[i] == bus.entry_hi_W[31:13]) &&
                           (r_g[i] || (r_asid[i] == bus.entry_hi_W[7:0]));
        end
    end

    logic [INDEX_W-1:0] w_i_idx, w_d_idx, w_p_idx;
    assign w_i_idx = first_hit(w_i_match);
    assign w_d_idx = first_hit(w_d_match);
    assign w_p_idx = first_hit(w_p_match);

    // Data translation: kseg0/kseg1 bypass the TLB, everything else is mapped.
    logic        w_d_hit, w_d_mapped, w_d_act, w_d_v, w_d_d;
    logic [19:0] w_d_pfn;
    logic [2:0]  w_d_c;
    assign w_d_hit    = |w_d_match;
    assign w_d_mapped = bus.data_vaddr[31:30] != 2'b10;
    assign w_d_act    = bus.data_en && w_d_mapped;
    assign w_d_pfn    = bus.data_vaddr[12] ? r_pfn1[w_d_idx] : r_pfn0[w_d_idx];
    assign w_d_c      = bus.data_vaddr[12] ? r_c1[w_d_idx]   : r_c0[w_d_idx];
    assign w_d_v      = bus.data_vaddr[12] ? r_v1[w_d_idx]   : r_v0[w_d_idx];
    assign w_d_d      = bus.data_vaddr[12] ? r_d1[w_d_idx]   : r_d0[w_d_idx];

    assign bus.data_paddr       = w_d_mapped ? {w_d_pfn, bus.data_vaddr[11:0]}
                                             : {3'b000, bus.data_vaddr[28:0]};
    assign bus.data_uncached    = (bus.data_vaddr[31:29] == 3'b101) ||
                                  (w_d_mapped && w_d_hit && (w_d_c == 3'd2));
    assign bus.data_tlb_refill  = w_d_act && !w_d_hit;
    assign bus.data_tlb_invalid = w_d_act && w_d_hit && !w_d_v;
    assign bus.data_tlb_modify  = w_d_act && bus.mem_write && w_d_hit && w_d_v && !w_d_d;

    // Fetch translation from the main TLB; the micro-TLB (if built) overrides it.
    logic        w_i_hit, w_i_mapped, w_m_v;
    logic [19:0] w_m_pfn;
    logic [2:0]  w_m_c;
    logic        w_is_hit, w_is_v, w_i_stall;
    logic [19:0] w_is_pfn;
    logic [2:0]  w_is_c;
    assign w_i_hit    = |w_i_match;
    assign w_i_mapped = bus.inst_vaddr[31:30] != 2'b10;
    assign w_m_pfn    = bus.inst_vaddr[12] ? r_pfn1[w_i_idx] : r_pfn0[w_i_idx];
    assign w_m_c      = bus.inst_vaddr[12] ? r_c1[w_i_idx]   : r_c0[w_i_idx];
    assign w_m_v      = bus.inst_vaddr[12] ? r_v1[w_i_idx]   : r_v0[w_i_idx];

`ifdef MMU_ITLB_CACHE_EN
    logic        r_u_valid, r_u_g, r_u_v0, r_u_v1;
    logic [18:0] r_u_vpn2;
    logic [7:0]  r_u_asid, r_last_asid;
    logic [19:0] r_u_pfn0, r_u_pfn1;
    logic [2:0]  r_u_c0, r_u_c1;
    logic        w_u_hit, w_u_fill;

    assign w_u_hit  = r_u_valid && (r_u_vpn2 == bus.inst_vaddr[31:13]) &&
                      (r_u_g || (r_u_asid == bus.entry_hi_W[7:0]));
    // A refill result is never cached, so only a main-TLB match fills.
    assign w_u_fill = bus.inst_en && w_i_mapped && !w_u_hit && w_i_hit;

    // Micro-TLB: fill on a mapped miss, drop on any TLB write or ASID change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_u_valid <= 1'b0; r_u_g <= 1'b0; r_u_v0 <= 1'b0; r_u_v1 <= 1'b0;
            r_u_vpn2  <= '0;   r_u_asid <= '0; r_last_asid <= '0;
            r_u_pfn0  <= '0;   r_u_pfn1 <= '0; r_u_c0 <= '0;  r_u_c1 <= '0;
        end else begin
            r_last_asid <= bus.entry_hi_W[7:0];
            if (w_wr_en || (bus.entry_hi_W[7:0] != r_last_asid)) begin
                r_u_valid <= 1'b0;
            end else if (w_u_fill) begin
                r_u_valid <= 1'b1;
                r_u_vpn2  <= r_vpn2[w_i_idx];
                r_u_asid  <= r_asid[w_i_idx];
                r_u_g     <= r_g[w_i_idx];
                r_u_pfn0  <= r_pfn0[w_i_idx];
                r_u_pfn1  <= r_pfn1[w_i_idx];
                r_u_c0    <= r_c0[w_i_idx];
                r_u_c1    <= r_c1[w_i_idx];
                r_u_v0    <= r_v0[w_i_idx];
                r_u_v1    <= r_v1[w_i_idx];
            end
        end
    end

    assign w_is_hit  = w_u_hit || w_i_hit;
    assign w_is_pfn  = !w_u_hit ? w_m_pfn : (bus.inst_vaddr[12] ? r_u_pfn1 : r_u_pfn0);
    assign w_is_c    = !w_u_hit ? w_m_c   : (bus.inst_vaddr[12] ? r_u_c1   : r_u_c0);
    assign w_is_v    = !w_u_hit ? w_m_v   : (bus.inst_vaddr[12] ? r_u_v1   : r_u_v0);
    assign w_i_stall = w_u_fill;
`else
    assign w_is_hit  = w_i_hit;
    assign w_is_pfn  = w_m_pfn;
    assign w_is_c    = w_m_c;
    assign w_is_v    = w_m_v;
    assign w_i_stall = 1'b0;
`endif

    assign bus.itlb_stall       = w_i_stall;
    assign bus.inst_paddr       = w_i_mapped ? {w_is_pfn, bus.inst_vaddr[11:0]}
                                             : {3'b000, bus.inst_vaddr[28:0]};
    assign bus.inst_uncached    = (bus.inst_vaddr[31:29] == 3'b101) ||
                                  (w_i_mapped && w_is_hit && (w_is_c == 3'd2));
    assign bus.inst_tlb_refill  = bus.inst_en && w_i_mapped && !w_is_hit;
    assign bus.inst_tlb_invalid = bus.inst_en && w_i_mapped && w_is_hit && !w_i_stall && !w_is_v;

    // TLBP result and TLBR readback, both combinational for CP0 to sample.
    logic [INDEX_W-1:0] w_r_idx;
    assign w_r_idx           = bus.index_W[INDEX_W-1:0];
    assign bus.index_out     = {!(|w_p_match), {(31 - INDEX_W){1'b0}}, w_p_idx};
    assign bus.entry_hi_out  = {r_vpn2[w_r_idx], 5'b00000, r_asid[w_r_idx]};
    assign bus.page_mask_out = {7'b0000000, r_mask[w_r_idx], 13'b0};
    assign bus.entry_lo0_out = {6'b000000, r_pfn0[w_r_idx], r_c0[w_r_idx],
                                r_d0[w_r_idx], r_v0[w_r_idx], r_g[w_r_idx]};
    assign bus.entry_lo1_out = {6'b000000, r_pfn1[w_r_idx], r_c1[w_r_idx],
                                r_d1[w_r_idx], r_v1[w_r_idx], r_g[w_r_idx]};

    // CP0 register bits with no meaning for a 4 KB-only TLB.
    logic w_unused;
    assign w_unused = ^{bus.tlb_type[1:0], bus.entry_hi_W[12:8], bus.page_mask_W[31:25],
                        bus.page_mask_W[12:0], bus.entry_lo0_W[31:26], bus.entry_lo1_W[31:26],
                        bus.index_W[31:INDEX_W], bus.random_i[31:INDEX_W]};
endmodule

// File: tb/tb_mmu_tlb.sv
// tb_mmu_tlb: directed bench for mmu_tlb. Expected values are queued as each
// step is driven and compared at the following falling edge.
module tb_mmu_tlb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mmu_tlb_if bus();
    mmu_tlb #(.TLB_LINE_NUM(16), .INDEX_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef enum int {
        O_DPADDR, O_DUNC, O_DREFILL, O_DINV, O_DMOD,
        O_IPADDR, O_IUNC, O_IREFILL, O_IINV, O_ISTALL,
        O_INDEX, O_HI, O_PM, O_LO0, O_LO1
    } sel_e;

    sel_e        q_sel[$];
    string       q_tag[$];
    logic [31:0] q_exp[$];
    int n_checks = 0;
    int n_errors = 0;

    localparam logic [3:0] T_WR = 4'b1000;
    localparam logic [3:0] T_WI = 4'b0100;

    function automatic logic [31:0] observe(input sel_e s);
        case (s)
            O_DPADDR:  return bus.data_paddr;
            O_DUNC:    return {31'b0, bus.data_uncached};
            O_DREFILL: return {31'b0, bus.data_tlb_refill};
            O_DINV:    return {31'b0, bus.data_tlb_invalid};
            O_DMOD:    return {31'b0, bus.data_tlb_modify};
            O_IPADDR:  return bus.inst_paddr;
            O_IUNC:    return {31'b0, bus.inst_uncached};
            O_IREFILL: return {31'b0, bus.inst_tlb_refill};
            O_IINV:    return {31'b0, bus.inst_tlb_invalid};
            O_ISTALL:  return {31'b0, bus.itlb_stall};
            O_INDEX:   return bus.index_out;
            O_HI:      return bus.entry_hi_out;
            O_PM:      return bus.page_mask_out;
            O_LO0:     return bus.entry_lo0_out;
            O_LO1:     return bus.entry_lo1_out;
            default:   return 'x;
        endcase
    endfunction

    task automatic expect_sig(input sel_e s, input string tag, input logic [31:0] e);
        q_sel.push_back(s);
        q_tag.push_back(tag);
        q_exp.push_back(e);
    endtask

    task automatic expect_data(input string t, input logic [31:0] pa,
                               input logic rf, input logic iv, input logic md);
        expect_sig(O_DPADDR,  {t, "_paddr"},   pa);
        expect_sig(O_DREFILL, {t, "_refill"},  {31'b0, rf});
        expect_sig(O_DINV,    {t, "_invalid"}, {31'b0, iv});
        expect_sig(O_DMOD,    {t, "_modify"},  {31'b0, md});
    endtask

    // Compare everything queued for this cycle, then move to just after the next edge.
    task automatic drain();
        sel_e        s;
        string       t;
        logic [31:0] e, obs;
        @(negedge clk);
        while (q_sel.size() > 0) begin
            s = q_sel.pop_front();
            t = q_tag.pop_front();
            e = q_exp.pop_front();
            obs = observe(s);
            n_checks++;
            assert (obs === e) else begin
                n_errors++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tlb_write(input logic [3:0] t, input logic [31:0] idx, input logic [31:0] hi,
                             input logic [31:0] lo0, input logic [31:0] lo1, input logic [31:0] pm);
        bus.tlb_type    = t;
        bus.index_W     = idx;
        bus.entry_hi_W  = hi;
        bus.entry_lo0_W = lo0;
        bus.entry_lo1_W = lo1;
        bus.page_mask_W = pm;
        drain();
        bus.tlb_type = 4'b0000;
    endtask

    initial begin
        rst = 1'b1;
        bus.stallM = 1'b0; bus.inst_en = 1'b0; bus.inst_vaddr = '0;
        bus.data_en = 1'b0; bus.mem_write = 1'b0; bus.data_vaddr = '0;
        bus.tlb_type = '0; bus.entry_hi_W = '0; bus.page_mask_W = '0;
        bus.entry_lo0_W = '0; bus.entry_lo1_W = '0; bus.index_W = '0; bus.random_i = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state: all flags low with enables low.
        expect_data("rst", 32'h0, 1'b0, 1'b0, 1'b0);
        expect_sig(O_IREFILL, "rst_irefill", 0);
        expect_sig(O_IINV, "rst_iinv", 0);
        expect_sig(O_ISTALL, "rst_istall", 0);
        drain();

        // All-zero entry 0 matches vaddr 0x10 with ASID 0 but is invalid.
        bus.data_en = 1'b1; bus.data_vaddr = 32'h0000_0010;
        expect_data("zero_entry", 32'h0000_0010, 1'b0, 1'b1, 1'b0);
        drain();

        // TLBWI entry 3; lookup in the write cycle still sees the old (empty) entry.
        bus.data_vaddr = 32'h0040_0123;
        expect_sig(O_DREFILL, "wr_cycle_old", 1);
        tlb_write(T_WI, 3, 32'h0040_0005, 32'h0000_1046, 32'h0000_1087, 32'h0001_E000);
        expect_data("even", 32'h0004_1123, 1'b0, 1'b0, 1'b0);
        expect_sig(O_LO0, "tlbr3_lo0", 32'h0000_1046);
        expect_sig(O_LO1, "tlbr3_lo1_g0", 32'h0000_1086);
        expect_sig(O_HI, "tlbr3_hi", 32'h0040_0005);
        expect_sig(O_PM, "tlbr3_pm", 32'h0001_E000);
        drain();
        bus.data_vaddr = 32'h0040_1123;
        expect_data("odd", 32'h0004_2123, 1'b0, 1'b0, 1'b0);
        drain();

        // Wrong ASID misses; global entry hits regardless of ASID.
        bus.entry_hi_W = 32'h0040_0006;
        expect_sig(O_DREFILL, "asid6_odd_refill", 1);
        drain();
        bus.data_vaddr = 32'h0040_0123;
        expect_sig(O_DREFILL, "asid6_even_refill", 1);
        drain();
        tlb_write(T_WI, 3, 32'h0040_0005, 32'h0000_1047, 32'h0000_1087, 32'h0);
        bus.entry_hi_W = 32'h0040_0006;
        expect_data("global", 32'h0004_1123, 1'b0, 1'b0, 1'b0);
        expect_sig(O_LO0, "tlbr3_lo0_g1", 32'h0000_1047);
        expect_sig(O_LO1, "tlbr3_lo1_g1", 32'h0000_1087);
        drain();

        // Entry 4: even page invalid, odd page valid, clean, C=2.
        tlb_write(T_WI, 4, 32'h0080_0005, 32'h0, 32'h0000_1552, 32'h0);
        bus.mem_write = 1'b1; bus.data_vaddr = 32'h0080_1234;
        expect_data("store_clean", 32'h0005_5234, 1'b0, 1'b0, 1'b1);
        expect_sig(O_DUNC, "store_c2_unc", 1);
        drain();
        bus.mem_write = 1'b0;
        expect_data("load_clean", 32'h0005_5234, 1'b0, 1'b0, 1'b0);
        drain();
        bus.mem_write = 1'b1; bus.data_vaddr = 32'h0080_0234;
        expect_data("store_inv", 32'h0000_0234, 1'b0, 1'b1, 1'b0);
        drain();

        // Unmapped segments.
        bus.mem_write = 1'b0; bus.data_vaddr = 32'h8000_1000;
        bus.inst_en = 1'b1; bus.inst_vaddr = 32'hBFC0_0000;
        expect_data("kseg0", 32'h0000_1000, 1'b0, 1'b0, 1'b0);
        expect_sig(O_DUNC, "kseg0_unc", 0);
        expect_sig(O_IPADDR, "kseg1_ipaddr", 32'h1FC0_0000);
        expect_sig(O_IUNC, "kseg1_iunc", 1);
        expect_sig(O_IREFILL, "kseg1_irefill", 0);
        expect_sig(O_IINV, "kseg1_iinv", 0);
        drain();
        bus.mem_write = 1'b1; bus.data_vaddr = 32'hA000_0040;
        expect_data("kseg1_store", 32'h0000_0040, 1'b0, 1'b0, 1'b0);
        expect_sig(O_DUNC, "kseg1_dunc", 1);
        bus.mem_write = 1'b1;
        drain();
        bus.mem_write = 1'b0;

        // Instruction refill: never cached, never stalls.
        bus.inst_vaddr = 32'h7000_0000;
        expect_sig(O_IREFILL, "inst_refill", 1);
        expect_sig(O_IINV, "inst_refill_inv", 0);
        expect_sig(O_ISTALL, "inst_refill_stall", 0);
        drain();
        bus.inst_en = 1'b0;

        // TLBP hit, miss and lowest-index priority.
        bus.entry_hi_W = 32'h0040_0005;
        expect_sig(O_INDEX, "tlbp_hit", 32'h0000_0003);
        drain();
        bus.entry_hi_W = 32'h0123_4005;
        expect_sig(O_INDEX, "tlbp_miss", 32'h8000_0000);
        drain();
        tlb_write(T_WI, 10, 32'h0080_0005, 32'h0, 32'h0000_1F46, 32'h0);
        bus.data_vaddr = 32'h0080_1234;
        expect_sig(O_INDEX, "tlbp_lowest", 32'h0000_0004);
        expect_data("multi_match", 32'h0005_5234, 1'b0, 1'b0, 1'b0);
        drain();

        // TLBWR blocked by stallM, then allowed.
        bus.random_i = 32'd9; bus.stallM = 1'b1;
        tlb_write(T_WR, 9, 32'h0100_0007, 32'h0000_2046, 32'h0000_2086, 32'h0);
        bus.stallM = 1'b0;
        expect_sig(O_HI, "tlbwr_stalled_hi", 32'h0);
        expect_sig(O_LO0, "tlbwr_stalled_lo0", 32'h0);
        drain();
        tlb_write(T_WR, 9, 32'h0100_0007, 32'h0000_2046, 32'h0000_2086, 32'h0);
        expect_sig(O_HI, "tlbwr_hi", 32'h0100_0007);
        expect_sig(O_LO0, "tlbwr_lo0", 32'h0000_2046);
        drain();

        // Mapped fetch of a valid global page.
        bus.entry_hi_W = 32'h0040_0005;
        expect_sig(O_INDEX, "pre_fetch_tlbp", 32'h0000_0003);
        drain();
        bus.inst_en = 1'b1; bus.inst_vaddr = 32'h0040_0010;
`ifdef MMU_ITLB_CACHE_EN
        expect_sig(O_ISTALL, "utlb_miss_stall", 1);
        expect_sig(O_IREFILL, "utlb_miss_refill", 0);
        expect_sig(O_IINV, "utlb_miss_inv", 0);
        drain();
        expect_sig(O_ISTALL, "utlb_hit_stall", 0);
        expect_sig(O_IPADDR, "utlb_hit_paddr", 32'h0004_1010);
        expect_sig(O_IINV, "utlb_hit_inv", 0);
        drain();
        expect_sig(O_ISTALL, "utlb_hit_during_wr", 0);
        tlb_write(T_WI, 7, 32'h0200_0005, 32'h0, 32'h0, 32'h0);
        expect_sig(O_ISTALL, "utlb_after_wr_stall", 1);
        drain();
        expect_sig(O_ISTALL, "utlb_refilled_stall", 0);
        expect_sig(O_IPADDR, "utlb_refilled_paddr", 32'h0004_1010);
        drain();
`else
        expect_sig(O_ISTALL, "fetch_stall", 0);
        expect_sig(O_IPADDR, "fetch_paddr", 32'h0004_1010);
        expect_sig(O_IREFILL, "fetch_refill", 0);
        expect_sig(O_IINV, "fetch_inv", 0);
        expect_sig(O_IUNC, "fetch_unc", 0);
        drain();
`endif
        bus.inst_en = 1'b0;

        // Reset wins over a concurrent write and clears the table.
        rst = 1'b1;
        tlb_write(T_WI, 5, 32'h0300_0005, 32'h0000_0046, 32'h0000_0046, 32'h0);
        rst = 1'b0;
        expect_sig(O_HI, "rst_wr_hi5", 32'h0);
        expect_sig(O_LO0, "rst_wr_lo0_5", 32'h0);
        drain();
        bus.index_W = 32'd3; bus.entry_hi_W = 32'h0040_0005; bus.data_vaddr = 32'h0040_0123;
        expect_sig(O_HI, "rst_hi3", 32'h0);
        expect_sig(O_DREFILL, "rst_lookup_refill", 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mmu_tlb.md
Name: mmu_tlb

Overview:
- Joint TLB and address-translation unit.
- Sits between the fetch/memory stages and the CP0 exception block.
- Translates instruction and data virtual addresses, and produces the inst/data refill, invalid and modify flags that CP0 turns into exceptions.
- Executes TLBP/TLBR/TLBWI/TLBWR using the CP0 EntryHi/EntryLo0/EntryLo1/PageMask/Index/Random values, and returns probe/read results to CP0.

Parameters:
- TLB_LINE_NUM, 16, number of TLB entries (must match CP0 Random range).
- INDEX_W, 4, log2(TLB_LINE_NUM); width of the Index field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stallM  in  1  memory-stage stall; blocks TLB writes
- inst_en  in  1  fetch request valid
- inst_vaddr  in  32  fetch virtual address
- data_en  in  1  load/store valid in execute stage
- mem_write  in  1  access is a store
- data_vaddr  in  32  data virtual address (aluoutE)
- tlb_type  in  4  {tlbwr, tlbwi, tlbr, tlbp}, one-hot or zero
- entry_hi_W, page_mask_W, entry_lo0_W, entry_lo1_W, index_W  in  32 each  current CP0 register values
- random_i  in  32  CP0 Random
- inst_paddr  out  32  fetch physical address
- data_paddr  out  32  data physical address
- inst_uncached, data_uncached  out  1 each  kseg1 access, or C==2
- inst_tlb_refill, inst_tlb_invalid  out  1 each
- data_tlb_refill, data_tlb_invalid, data_tlb_modify  out  1 each
- index_out  out  32  TLBP result
- entry_hi_out, page_mask_out, entry_lo0_out, entry_lo1_out  out  32 each  TLBR result
- itlb_stall  out  1  fetch stall request (optional feature only)

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst.
- Entry fields:
  - VPN2[18:0], ASID[7:0], G, MASK[11:0].
  - Even page: PFN0[19:0], C0[2:0], D0, V0.
  - Odd page: PFN1[19:0], C1[2:0], D1, V1.
- Reset: all entry fields cleared to 0. All outputs combinationally derived, so after reset every flag is 0 while en is low.
- Segments:
  - kseg0 (0x8000_0000–0x9FFF_FFFF) and kseg1 (0xA000_0000–0xBFFF_FFFF) are unmapped: paddr = vaddr & 0x1FFF_FFFF, no TLB flags.
  - kseg1 is uncached. kseg0 is cacheable.
  - kuseg and kseg2/3 are mapped.
- Match rule: entry i matches when VPN2 == vaddr[31:13] && (G || ASID == entry_hi_W[7:0]).
  - 4 KB pages only. MASK is stored and returned by TLBR but ignored for matching.
  - Multiple matches: lowest index wins.
- Page select: vaddr[12] selects odd (1) or even (0). paddr = {PFN[19:0], vaddr[11:0]}.
- Flags (mapped accesses only, gated by inst_en/data_en):
  - refill = no match.
  - invalid = match && !V.
  - modify = data && mem_write && match && V && !D.
  - All three are mutually exclusive.
- Lookup latency: 0 cycles, combinational, from vaddr and the current entry array.
- TLBP: index_out = {miss, 27'b0, idx} using entry_hi_W VPN2/ASID; idx = 0 on miss. Combinational; CP0 samples it in the same cycle.
- TLBR: the *_out buses return the entry at index_W[INDEX_W-1:0].
  - entry_lo G bit = entry G.
  - entry_hi_out = {VPN2, 5'b0, ASID}.
  - page_mask_out = {7'b0, MASK, 13'b0}.
- TLBWI/TLBWR write at posedge when !stallM.
  - Target index: index_W[INDEX_W-1:0] for TLBWI, random_i[INDEX_W-1:0] for TLBWR.
  - G = entry_lo0_W[0] & entry_lo1_W[0].
  - Fields taken from the CP0 bit positions (PFN 25:6, C 5:3, D 2, V 1).
- Simultaneous write and lookup to the same entry: the lookup sees the old entry in that cycle; the new entry is visible next cycle.
- Reset mid-write: reset wins; the entry is cleared.

Optional Feature:
- Macro MMU_ITLB_CACHE_EN.
- Defined: a one-entry instruction micro-TLB holds {valid, VPN2, ASID, G, PFN0/1, C0/1, V0/1} of the last mapped fetch.
  - Hit: translation comes from the micro-TLB.
  - Mapped miss: itlb_stall=1 for exactly one cycle. The main-TLB result is registered into the micro-TLB. The next cycle hits, with flags from the micro-TLB (refill is not cached; a refill result keeps valid=0 and raises inst_tlb_refill in the stall cycle with itlb_stall=0).
  - Invalidated on rst, any TLBWI/TLBWR write, or a change of entry_hi_W[7:0].
- Undefined: itlb_stall tied 0, and fetch uses the main TLB directly.

Test Plan:
- After rst, data_en=1, data_vaddr=0x0000_0010, entry_hi_W=0 -> data_tlb_invalid=1 (entry 0 all-zero matches), refill=0.
- TLBWI index=3, EntryHi=0x0040_0005, Lo0=0x0000_1046 (PFN 0x41, D=1, V=1, G=0), Lo1=0x0000_1087 -> next cycle a data read of 0x0040_0123 with ASID 5 gives paddr 0x0004_1123 and no flags; a read of 0x0040_1123 gives paddr 0x0004_2123.
- Same entry, ASID changed to 6 -> refill=1 for both addresses. Rewrite with G set in both Lo -> hit with ASID 6.
- Store to an odd page with D1=0 -> data_tlb_modify=1. Load from the same address -> no flag. inst_vaddr=0xBFC0_0000 -> paddr 0x1FC0_0000, uncached=1, no flags.
- TLBP with EntryHi matching entry 3 -> index_out=0x0000_0003. Non-matching -> 0x8000_0000. TLBR index=3 -> entry_lo0_out=0x0000_1046. TLBWR with random_i=9 and stallM=1 -> no write (TLBR index 9 still 0).
- MMU_ITLB_CACHE_EN: first fetch of 0x0040_0000 -> itlb_stall=1 for one cycle, then hit. A TLBWI in between -> the following fetch stalls again.
